// File: rtl/timer_capture_pkg.sv
// Shared types for the timer input-capture channel: FSM state encoding and status bit positions.
package timer_capture_pkg;

  typedef enum logic [1:0] {
    CAP_IDLE,
    CAP_ARM,
    CAP_HIGH,
    CAP_LOW
  } cap_state_e;

  localparam int ST_BUSY  = 0;
  localparam int ST_ARMED = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_RES   = 3;

endpackage

// File: rtl/timer_capture_if.sv
// Configuration and result bundle of the capture channel; master = register file side, slave = capture core.
interface timer_capture_if #(
  parameter int NUM_BITS = 16
);
  logic                cfg_start_i;
  logic                cfg_stop_i;
  logic [7:0]          cfg_sel_i;
  logic [7:0]          cfg_presc_i;
  logic                cfg_continuous_i;
  logic [3:0]          cfg_filt_i;
  logic [NUM_BITS-1:0] period_o;
  logic [NUM_BITS-1:0] high_o;
  logic                valid_o;
  logic [7:0]          status_o;

  modport master (
    output cfg_start_i, cfg_stop_i, cfg_sel_i, cfg_presc_i, cfg_continuous_i, cfg_filt_i,
    input  period_o, high_o, valid_o, status_o
  );

  modport slave (
    input  cfg_start_i, cfg_stop_i, cfg_sel_i, cfg_presc_i, cfg_continuous_i, cfg_filt_i,
    output period_o, high_o, valid_o, status_o
  );
endinterface

// File: rtl/capture_edge_detect.sv
// Selects one external signal, synchronizes it, optionally glitch-filters it, and emits rise/fall pulses.
// Filter present only when CAPTURE_GLITCH_FILTER_EN is defined.
module capture_edge_detect #(
  parameter int N_EXTSIG = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_EXTSIG-1:0] signal_i,
  input  logic [7:0]          sel_i,
  input  logic [3:0]          filt_i,
  output logic                rise_o,
  output logic                fall_o
);

  localparam int SELW = (N_EXTSIG > 1) ? $clog2(N_EXTSIG) : 1;

  logic       sel_sig;
  logic [1:0] sync_q;
  logic       lvl;
  logic       lvl_q;

  // Out-of-range selections read as a constant low line.
  always_comb begin
    sel_sig = 1'b0;
    if (int'(sel_i) < N_EXTSIG) begin
      sel_sig = signal_i[sel_i[SELW-1:0]];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], sel_sig};
    end
  end

`ifdef CAPTURE_GLITCH_FILTER_EN
  logic       filt_lvl_q;
  logic [3:0] fcnt_q;

  // A new level must persist for filt_i+1 consecutive clocks before it is accepted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      filt_lvl_q <= 1'b0;
      fcnt_q     <= 4'd0;
    end else if (sync_q[1] == filt_lvl_q) begin
      fcnt_q <= 4'd0;
    end else if (fcnt_q == filt_i) begin
      filt_lvl_q <= sync_q[1];
      fcnt_q     <= 4'd0;
    end else begin
      fcnt_q <= fcnt_q + 4'd1;
    end
  end

  assign lvl = filt_lvl_q;
`else
  logic unused_filt;
  assign unused_filt = ^filt_i;
  assign lvl         = sync_q[1];
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lvl_q <= 1'b0;
    end else begin
      lvl_q <= lvl;
    end
  end

  assign rise_o = lvl & ~lvl_q;
  assign fall_o = ~lvl & lvl_q;

endmodule

// File: rtl/timer_capture.sv
// Input-capture channel: measures period and high time of a selected external signal in prescaled ticks.
// Optional glitch filter enabled by defining CAPTURE_GLITCH_FILTER_EN.
module timer_capture
  import timer_capture_pkg::*;
#(
  parameter int NUM_BITS = 16,
  parameter int N_EXTSIG = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_EXTSIG-1:0] signal_i,
  timer_capture_if.slave      cap_if
);

  cap_state_e          state_q, state_d;
  logic [7:0]          sel_q, presc_q;
  logic                cont_q;
  logic [3:0]          filt_q;
  logic [7:0]          pcnt_q, pcnt_d;
  logic [NUM_BITS-1:0] cnt_q, cnt_d;
  logic [NUM_BITS-1:0] high_lat_q, high_lat_d;
  logic [NUM_BITS-1:0] period_q, period_d;
  logic [NUM_BITS-1:0] high_q, high_d;
  logic                valid_q, valid_d;
  logic                ovf_q, ovf_d;
  logic                res_q, res_d;
  logic [7:0]          status_q, status_d;
  logic                rise, fall, tick, cnt_full;
  logic [NUM_BITS-1:0] cap_val;
  logic                start_ok;

  capture_edge_detect #(
    .N_EXTSIG (N_EXTSIG)
  ) u_edge (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .signal_i (signal_i),
    .sel_i    (sel_q),
    .filt_i   (filt_q),
    .rise_o   (rise),
    .fall_o   (fall)
  );

  assign start_ok = cap_if.cfg_start_i & ~cap_if.cfg_stop_i;
  assign tick     = (pcnt_q == presc_q);
  assign cnt_full = &cnt_q;
  // Captured value includes this cycle's tick: ticks elapsed since the last rising edge.
  assign cap_val  = cnt_q + NUM_BITS'(tick);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pcnt_d     = pcnt_q + 8'd1;
    high_lat_d = high_lat_q;
    period_d   = period_q;
    high_d     = high_q;
    valid_d    = 1'b0;
    ovf_d      = ovf_q;
    res_d      = res_q;

    if (rise || start_ok) begin
      cnt_d  = '0;
      pcnt_d = 8'd0;
    end else if (tick) begin
      cnt_d  = cnt_q + NUM_BITS'(1);
      pcnt_d = 8'd0;
    end

    if (cap_if.cfg_stop_i) begin
      state_d = CAP_IDLE;
    end else if (cap_if.cfg_start_i) begin
      state_d = CAP_ARM;
      ovf_d   = 1'b0;
      res_d   = 1'b0;
    end else begin
      case (state_q)
        CAP_ARM: begin
          if (rise) state_d = CAP_HIGH;
        end
        CAP_HIGH: begin
          if (tick && cnt_full) begin
            ovf_d   = 1'b1;
            state_d = CAP_IDLE;
          end else if (fall) begin
            high_lat_d = cap_val;
            state_d    = CAP_LOW;
          end
        end
        CAP_LOW: begin
          if (tick && cnt_full) begin
            ovf_d   = 1'b1;
            state_d = CAP_IDLE;
          end else if (rise) begin
            period_d = cap_val;
            high_d   = high_lat_q;
            valid_d  = 1'b1;
            res_d    = 1'b1;
            state_d  = cont_q ? CAP_HIGH : CAP_IDLE;
          end
        end
        default: state_d = CAP_IDLE;
      endcase
    end
  end

  always_comb begin
    status_d           = 8'h00;
    status_d[ST_BUSY]  = (state_q != CAP_IDLE);
    status_d[ST_ARMED] = (state_q == CAP_ARM);
    status_d[ST_OVF]   = ovf_q;
    status_d[ST_RES]   = res_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= CAP_IDLE;
      sel_q      <= 8'd0;
      presc_q    <= 8'd0;
      cont_q     <= 1'b0;
      filt_q     <= 4'd0;
      pcnt_q     <= 8'd0;
      cnt_q      <= '0;
      high_lat_q <= '0;
      period_q   <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      res_q      <= 1'b0;
      status_q   <= 8'h00;
    end else begin
      if (start_ok) begin
        sel_q   <= cap_if.cfg_sel_i;
        presc_q <= cap_if.cfg_presc_i;
        cont_q  <= cap_if.cfg_continuous_i;
        filt_q  <= cap_if.cfg_filt_i;
      end
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      cnt_q      <= cnt_d;
      high_lat_q <= high_lat_d;
      period_q   <= period_d;
      high_q     <= high_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      res_q      <= res_d;
      status_q   <= status_d;
    end
  end

  assign cap_if.period_o = period_q;
  assign cap_if.high_o   = high_q;
  assign cap_if.valid_o  = valid_q;
  assign cap_if.status_o = status_q;

endmodule
